rob_commit: RTL

- Retire-side reader of the reorder buffer: inspects the ROB head entry every cycle and commits it in program order.
- Commit actions: architectural register writeback, store-buffer request handshake, CP0 write, branch-predictor update, exception/mispredict flush.
- Pops the head only when every side effect of that entry has completed.
- Sits between ROB storage and the regfile, memory, CP0 and predictor interfaces.

---
 rtl/rob_commit_pkg.sv | 22 ++
 rtl/rob_commit_perf.sv | 23 ++
 rtl/rob_commit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// Shared definitions for the ROB commit stage: default widths,
// exception vector, commit FSM states and redirect helper.
package rob_commit_pkg;

    localparam int GHR_WIDTH      = 5;
    localparam int EXC_TYPE_WIDTH = 8;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    typedef enum logic [1:0] {
        COMMIT,
        STORE_WAIT,
        WAIT_DS,
        FLUSH
    } state_t;

    // Fall-through fetch address after a not-taken branch and its delay slot.
    function automatic logic [31:0] seq_redirect(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/rob_commit_perf.sv
// Commit / mispredict event counters; instantiated by rob_commit only
// when ROB_COMMIT_PERF_CNT_EN is defined. Both counters wrap at 2^32.
module rob_commit_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_evt,
    input  logic        mispredict_evt,
    output logic [31:0] perf_commit_cnt,
    output logic [31:0] perf_mispredict_cnt
);

    // Count retired instructions and detected mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt     <= '0;
            perf_mispredict_cnt <= '0;
        end else begin
            if (commit_evt)     perf_commit_cnt     <= perf_commit_cnt + 32'd1;
            if (mispredict_evt) perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/rob_commit.sv
// ROB retire stage: commits the head entry in program order, driving
// regfile, store, CP0, predictor and flush/exception interfaces.
// Optional macro ROB_COMMIT_PERF_CNT_EN adds commit/mispredict counters.
module rob_commit #(
    parameter int GHR_WIDTH      = rob_commit_pkg::GHR_WIDTH,
    parameter int EXC_TYPE_WIDTH = rob_commit_pkg::EXC_TYPE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      head_valid,
    input  logic                      head_done,
    input  logic                      head_reg_write_en,
    input  logic [4:0]                head_reg_write_addr,
    input  logic [31:0]               head_result_data,
    input  logic                      head_is_inst_branch,
    input  logic                      head_pred_taken,
    input  logic                      head_actual_taken,
    input  logic [GHR_WIDTH-1:0]      head_pht_index,
    input  logic [31:0]               head_branch_target,
    input  logic                      head_is_delayslot,
    input  logic                      head_mem_write_flag,
    input  logic [31:0]               head_mem_addr,
    input  logic [3:0]                head_mem_sel,
    input  logic [31:0]               head_mem_write_data,
    input  logic                      head_cp0_write_flag,
    input  logic [7:0]                head_cp0_addr,
    input  logic [31:0]               head_cp0_write_data,
    input  logic [EXC_TYPE_WIDTH-1:0] head_exception_type,
    input  logic [31:0]               head_pc,
    input  logic                      store_ack,
    output logic                      head_pop,
    output logic                      rf_write_en,
    output logic [4:0]                rf_write_addr,
    output logic [31:0]               rf_write_data,
    output logic                      store_req,
    output logic [31:0]               store_addr,
    output logic [3:0]                store_sel,
    output logic [31:0]               store_data,
    output logic                      cp0_write_en,
    output logic [7:0]                cp0_addr,
    output logic [31:0]               cp0_data,
    output logic                      bp_update_en,
    output logic [GHR_WIDTH-1:0]      bp_pht_index,
    output logic                      bp_taken,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic                      exc_valid,
    output logic [EXC_TYPE_WIDTH-1:0] exc_type,
    output logic [31:0]               exc_pc,
    output logic                      exc_is_delayslot
`ifdef ROB_COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]               perf_commit_cnt,
    output logic [31:0]               perf_mispredict_cnt
`endif
);

    import rob_commit_pkg::*;

    state_t      state, state_d;
    logic [31:0] redirect;
    logic        redirect_pending, pending_d;

    logic        head_ready, has_exc, mispredict;
    logic        rf_we_d, cp0_we_d, bp_en_d, flush_d, exc_d;
    logic [31:0] flush_pc_d;
    logic        store_start, store_done, redirect_load;

    assign head_ready = head_valid && head_done;
    assign has_exc    = |head_exception_type;
    assign mispredict = head_is_inst_branch && (head_pred_taken != head_actual_taken);

    // Next-state, head_pop and next values of the registered outputs.
    // A delay-slot store defers the mispredict redirect until its ack,
    // tracked by redirect_pending.
    always_comb begin
        state_d       = state;
        pending_d     = redirect_pending;
        head_pop      = 1'b0;
        rf_we_d       = 1'b0;
        cp0_we_d      = 1'b0;
        bp_en_d       = 1'b0;
        flush_d       = 1'b0;
        flush_pc_d    = '0;
        exc_d         = 1'b0;
        store_start   = 1'b0;
        store_done    = 1'b0;
        redirect_load = 1'b0;
        if (!rst) begin
            case (state)
                COMMIT: begin
                    if (head_ready) begin
                        if (has_exc) begin
                            head_pop   = 1'b1;
                            exc_d      = 1'b1;
                            flush_d    = 1'b1;
                            flush_pc_d = EXC_VECTOR;
                            state_d    = FLUSH;
                        end else if (head_mem_write_flag) begin
                            store_start = 1'b1;
                            pending_d   = 1'b0;
                            state_d     = STORE_WAIT;
                        end else begin
                            head_pop = 1'b1;
                            rf_we_d  = head_reg_write_en && (head_reg_write_addr != 5'd0);
                            cp0_we_d = head_cp0_write_flag;
                            bp_en_d  = head_is_inst_branch;
                            if (mispredict) begin
                                redirect_load = 1'b1;
                                state_d       = WAIT_DS;
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    if (store_ack) begin
                        head_pop   = 1'b1;
                        store_done = 1'b1;
                        if (redirect_pending) begin
                            flush_d    = 1'b1;
                            flush_pc_d = redirect;
                            pending_d  = 1'b0;
                            state_d    = FLUSH;
                        end else begin
                            state_d = COMMIT;
                        end
                    end
                end
                WAIT_DS: begin
                    if (head_ready) begin
                        if (!head_is_delayslot) begin
                            flush_d    = 1'b1;
                            flush_pc_d = redirect;
                            state_d    = FLUSH;
                        end else if (has_exc) begin
                            head_pop   = 1'b1;
                            exc_d      = 1'b1;
                            flush_d    = 1'b1;
                            flush_pc_d = EXC_VECTOR;
                            state_d    = FLUSH;
                        end else if (head_mem_write_flag) begin
                            store_start = 1'b1;
                            pending_d   = 1'b1;
                            state_d     = STORE_WAIT;
                        end else begin
                            head_pop   = 1'b1;
                            rf_we_d    = head_reg_write_en && (head_reg_write_addr != 5'd0);
                            cp0_we_d   = head_cp0_write_flag;
                            bp_en_d    = head_is_inst_branch;
                            flush_d    = 1'b1;
                            flush_pc_d = redirect;
                            state_d    = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_d = COMMIT;
                end
                default: begin
                    state_d = COMMIT;
                end
            endcase
        end
    end

    // State register and latched mispredict redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= COMMIT;
            redirect         <= '0;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_d;
            redirect_pending <= pending_d;
            if (redirect_load)
                redirect <= head_actual_taken ? head_branch_target : seq_redirect(head_pc);
        end
    end

    // Registered side-effect outputs; pulses clear to zero, store fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en      <= 1'b0;
            rf_write_addr    <= '0;
            rf_write_data    <= '0;
            store_req        <= 1'b0;
            store_addr       <= '0;
            store_sel        <= '0;
            store_data       <= '0;
            cp0_write_en     <= 1'b0;
            cp0_addr         <= '0;
            cp0_data         <= '0;
            bp_update_en     <= 1'b0;
            bp_pht_index     <= '0;
            bp_taken         <= 1'b0;
            flush            <= 1'b0;
            flush_pc         <= '0;
            exc_valid        <= 1'b0;
            exc_type         <= '0;
            exc_pc           <= '0;
            exc_is_delayslot <= 1'b0;
        end else begin
            rf_write_en      <= rf_we_d;
            rf_write_addr    <= rf_we_d ? head_reg_write_addr : '0;
            rf_write_data    <= rf_we_d ? head_result_data : '0;
            cp0_write_en     <= cp0_we_d;
            cp0_addr         <= cp0_we_d ? head_cp0_addr : '0;
            cp0_data         <= cp0_we_d ? head_cp0_write_data : '0;
            bp_update_en     <= bp_en_d;
            bp_pht_index     <= bp_en_d ? head_pht_index : '0;
            bp_taken         <= bp_en_d && head_actual_taken;
            flush            <= flush_d;
            flush_pc         <= flush_pc_d;
            exc_valid        <= exc_d;
            exc_type         <= exc_d ? head_exception_type : '0;
            exc_pc           <= exc_d ? head_pc : '0;
            exc_is_delayslot <= exc_d && head_is_delayslot;
            if (store_start) begin
                store_req  <= 1'b1;
                store_addr <= head_mem_addr;
                store_sel  <= head_mem_sel;
                store_data <= head_mem_write_data;
            end else if (store_done) begin
                store_req  <= 1'b0;
                store_addr <= '0;
                store_sel  <= '0;
                store_data <= '0;
            end
        end
    end

`ifdef ROB_COMMIT_PERF_CNT_EN
    rob_commit_perf u_perf (
        .clk                 (clk),
        .rst                 (rst),
        .commit_evt          (head_pop),
        .mispredict_evt      (redirect_load),
        .perf_commit_cnt     (perf_commit_cnt),
        .perf_mispredict_cnt (perf_mispredict_cnt)
    );
`endif

endmodule
